alu_uart_interface: RTL and testbench
=====================================

# alu_uart_interface

Sequencer between the UART and the combinational ALU. It collects three received bytes (operand A, operand B, opcode) and drives them onto the ALU inputs. It then captures the (NB_BITS+1)-bit ALU result and returns it to the host through the UART transmitter as two bytes.

## Interface
- NB_BITS, 8: operand width; also UART byte width.
- NB_OPE, 6: opcode width, taken from the low bits of the opcode byte.

- i_clock  input  1  system clock; all state changes on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_rx_data  input  NB_BITS  byte from the UART receiver; valid only while i_rx_done=1.
- i_rx_done  input  1  one-cycle strobe marking a received byte.
- o_dato_a  output  NB_BITS  operand A to the ALU (registered).
- o_dato_b  output  NB_BITS  operand B to the ALU (registered).
- o_ope_sel  output  NB_OPE  opcode to the ALU (registered).
- i_alu_result  input  NB_BITS+1  ALU result; bit NB_BITS is the carry/borrow.
- o_tx_data  output  NB_BITS  byte to the UART transmitter.
- o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
- i_tx_done  input  1  one-cycle strobe: the transmitter finished its byte.
- o_busy  output  1  high in any state other than WAIT_A.

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
- WAIT_A: on i_rx_done, latch i_rx_data into o_dato_a and go to WAIT_B.
- WAIT_B: on i_rx_done, latch into o_dato_b and go to WAIT_OP.
- WAIT_OP: on i_rx_done, latch i_rx_data[NB_OPE-1:0] into o_ope_sel and go to COMPUTE.
  - The upper byte bits are discarded.
- COMPUTE: one cycle, which lets the ALU settle on the registered inputs.
  - Capture i_alu_result into an internal result register.
  - Go to SEND_LO.
- SEND_LO: o_tx_data = result[NB_BITS-1:0]; o_tx_start = 1 for this cycle only; go to WAIT_LO.
- WAIT_LO: hold o_tx_data; on i_tx_done, go to SEND_HI.
- SEND_HI: o_tx_data = {(NB_BITS-1)'b0, result[NB_BITS]}; o_tx_start = 1 for one cycle; go to WAIT_HI.
- WAIT_HI: hold o_tx_data; on i_tx_done, go to WAIT_A.
- Unsupported opcodes are not checked here: the ALU default (0) is transmitted as 0x00, 0x00.
- i_rx_done in any state from COMPUTE through WAIT_HI is ignored; the byte is dropped.
- i_tx_done outside WAIT_LO/WAIT_HI is ignored.
- Operands and opcode persist after the transaction until overwritten by the next one.
  - The ALU output therefore stays stable between transactions.

## Timing
- Reset (i_reset=0, asynchronous) forces:
  - state to WAIT_A;
  - o_dato_a, o_dato_b, o_ope_sel, the result register and o_tx_data to 0;
  - o_tx_start and o_busy to 0.
- Deassertion takes effect at the next rising edge.
- Reset mid-transaction:
  - Any partial operand collection is abandoned.
  - Any pending transmit is abandoned.
  - No o_tx_start pulse is issued after reset releases until a full three-byte sequence is received again.
- Latency, taking edge N as the one that samples the opcode strobe:
  - COMPUTE during cycle N+1.
  - o_tx_start high during cycle N+2, with o_tx_data valid in the same cycle.
- Second-byte latency: edge M samples i_tx_done in WAIT_LO; SEND_HI (o_tx_start high) occurs during cycle M+1.
- o_tx_data is stable from the o_tx_start cycle until the matching i_tx_done.
- o_tx_start is never high for two consecutive cycles.
- Back-to-back transactions: a new A byte is accepted starting in the cycle after the final i_tx_done.
  - i_rx_done in the same cycle as that final i_tx_done is dropped.
- o_busy is a registered decode of the state: high from the cycle after the A strobe until return to WAIT_A.

## Test plan
- ADD: rx 0x05, 0x03, 0x20 → tx 0x08 then 0x00; o_dato_a=0x05, o_dato_b=0x03, o_ope_sel=0x20 held afterwards.
- ADD with carry: rx 0xFF, 0x01, 0x20 → tx 0x00 then 0x01.
- SUB with borrow: rx 0x03, 0x05, 0x22 → tx 0xFE then 0x01.
- Opcode masking and invalid op: rx 0x0F, 0x0F, 0xE4 → o_ope_sel=0x24 (AND), tx 0x0F, 0x00. Then rx 0x0F, 0x0F, 0x3F → tx 0x00, 0x00.
- Dropped bytes: send extra i_rx_done 0xAA while in WAIT_LO → no state change, tx 0x08/0x00 sequence unaffected, next transaction starts cleanly.
- Reset mid-operation:
  - Stimulus: assert i_reset=0 after the B byte (state WAIT_OP).
  - All outputs go to 0 immediately.
  - A following lone opcode byte 0x20 is latched as operand A; no o_tx_start.
  - Timing check: o_tx_start occurs exactly 2 cycles after the opcode strobe, and exactly 1 cycle after the first i_tx_done.

Source files
------------

// File: rtl/alu_uart_interface.sv
// Sequencer between a UART and a combinational ALU: it collects operand A, operand B
// and the opcode, then returns the (NB_BITS+1)-bit result as a low byte and a carry byte.
module alu_uart_interface #(
  parameter int NB_BITS = 8,
  parameter int NB_OPE  = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BITS-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_BITS-1:0] o_dato_a,
  output logic [NB_BITS-1:0] o_dato_b,
  output logic [NB_OPE-1:0]  o_ope_sel,
  input  logic [NB_BITS:0]   i_alu_result,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    COMPUTE,
    SEND_LO,
    WAIT_LO,
    SEND_HI,
    WAIT_HI
  } state_e;

  state_e               state_q, state_d;
  logic [NB_BITS-1:0]   dato_a_q, dato_a_d;
  logic [NB_BITS-1:0]   dato_b_q, dato_b_d;
  logic [NB_OPE-1:0]    ope_sel_q, ope_sel_d;
  logic [NB_BITS:0]     result_q, result_d;
  logic [NB_BITS-1:0]   tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;

  // Every output is registered, so each transmit byte and its start pulse are
  // computed one state early and appear together on entry to SEND_LO / SEND_HI.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    ope_sel_d  = ope_sel_q;
    result_d   = result_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;

    unique case (state_q)
      WAIT_A: begin
        if (i_rx_done) begin
          dato_a_d = i_rx_data;
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          dato_b_d = i_rx_data;
          state_d  = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          ope_sel_d = i_rx_data[NB_OPE-1:0];
          state_d   = COMPUTE;
        end
      end
      COMPUTE: begin
        // The ALU has had a full cycle on the registered operands; its output is stable.
        result_d   = i_alu_result;
        tx_data_d  = i_alu_result[NB_BITS-1:0];
        tx_start_d = 1'b1;
        state_d    = SEND_LO;
      end
      SEND_LO: begin
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (i_tx_done) begin
          tx_data_d  = {{(NB_BITS-1){1'b0}}, result_q[NB_BITS]};
          tx_start_d = 1'b1;
          state_d    = SEND_HI;
        end
      end
      SEND_HI: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // A receive strobe coinciding with this final done is dropped on purpose.
        if (i_tx_done) begin
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase

    busy_d = (state_d != WAIT_A);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= WAIT_A;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      ope_sel_q  <= '0;
      result_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let all flops sample the old values at the
      // same edge; blocking ones here would create order-dependent races.
      state_q    <= state_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      ope_sel_q  <= ope_sel_d;
      result_q   <= result_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  assign o_dato_a   = dato_a_q;
  assign o_dato_b   = dato_b_q;
  assign o_ope_sel  = ope_sel_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface: a small ALU model closes the loop and each
// scenario task checks operands, transmit bytes and strobe timing against hand values.
module tb_alu_uart_interface;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] dato_a;
  logic [7:0] dato_b;
  logic [5:0] ope_sel;
  logic [8:0] alu_result;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_uart_interface #(.NB_BITS(8), .NB_OPE(6)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .o_dato_a     (dato_a),
    .o_dato_b     (dato_b),
    .o_ope_sel    (ope_sel),
    .i_alu_result (alu_result),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_done    (tx_done),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: ADD, SUB, AND, OR; anything else yields 0.
  always_comb begin
    case (ope_sel)
      6'h20:   alu_result = {1'b0, dato_a} + {1'b0, dato_b};
      6'h22:   alu_result = {1'b0, dato_a} - {1'b0, dato_b};
      6'h24:   alu_result = {1'b0, dato_a & dato_b};
      6'h25:   alu_result = {1'b0, dato_a | dato_b};
      default: alu_result = 9'h000;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one receive strobe; sampled by the next rising edge. Returns #1 after it.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  // Pulse i_tx_done for one sampling edge, optionally with a coincident rx strobe.
  task automatic pulse_tx_done(input bit with_rx, input logic [7:0] b);
    tx_done = 1'b1;
    if (with_rx) begin
      rx_data = b;
      rx_done = 1'b1;
    end
    @(posedge clk); #1;
    tx_done = 1'b0;
    rx_done = 1'b0;
  endtask

  // Watch negedges for o_tx_start; lat is the index of the first negedge showing it.
  task automatic wait_start(output bit found, output int lat);
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(negedge clk);
      if (tx_start) begin
        found = 1'b1;
        lat   = i;
      end
    end
  endtask

  task automatic run_txn(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [5:0] exp_op,
                         input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                         input bit drop_in_wait_lo, input bit rx_on_final_done);
    bit found;
    int lat;
    send_byte(a);
    send_byte(b);
    send_byte(op);

    total_cnt++;
    if ({dato_a, dato_b, ope_sel} !== {a, b, exp_op})
      $display("FAIL %s operands: got %h/%h/%h want %h/%h/%h", name, dato_a, dato_b, ope_sel, a, b, exp_op);
    else pass_cnt++;

    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy_compute: got %b want 1", name, busy);
    else pass_cnt++;

    wait_start(found, lat);
    total_cnt++;
    if (!found || lat != 2)
      $display("FAIL %s lo_start_latency: got found=%0d lat=%0d want lat=2", name, found, lat);
    else pass_cnt++;

    total_cnt++;
    if (tx_data !== exp_lo) $display("FAIL %s lo_byte: got %h want %h", name, tx_data, exp_lo);
    else pass_cnt++;

    @(negedge clk);
    total_cnt++;
    if (tx_start !== 1'b0 || tx_data !== exp_lo)
      $display("FAIL %s lo_hold: got start=%b data=%h want start=0 data=%h", name, tx_start, tx_data, exp_lo);
    else pass_cnt++;

    if (drop_in_wait_lo) begin
      send_byte(8'hAA);
      @(negedge clk);
      total_cnt++;
      if (dato_a !== a || busy !== 1'b1 || tx_start !== 1'b0 || tx_data !== exp_lo)
        $display("FAIL %s dropped_rx: got a=%h busy=%b start=%b data=%h want a=%h busy=1 start=0 data=%h",
                 name, dato_a, busy, tx_start, tx_data, a, exp_lo);
      else pass_cnt++;
    end

    pulse_tx_done(1'b0, 8'h00);
    wait_start(found, lat);
    total_cnt++;
    if (!found || lat != 1)
      $display("FAIL %s hi_start_latency: got found=%0d lat=%0d want lat=1", name, found, lat);
    else pass_cnt++;

    total_cnt++;
    if (tx_data !== exp_hi) $display("FAIL %s hi_byte: got %h want %h", name, tx_data, exp_hi);
    else pass_cnt++;

    @(negedge clk);
    total_cnt++;
    if (tx_start !== 1'b0 || tx_data !== exp_hi || busy !== 1'b1)
      $display("FAIL %s hi_hold: got start=%b data=%h busy=%b want start=0 data=%h busy=1",
               name, tx_start, tx_data, busy, exp_hi);
    else pass_cnt++;

    pulse_tx_done(rx_on_final_done, 8'h77);
    total_cnt++;
    if (busy !== 1'b0 || tx_start !== 1'b0)
      $display("FAIL %s idle_after: got busy=%b start=%b want busy=0 start=0", name, busy, tx_start);
    else pass_cnt++;

    total_cnt++;
    if ({dato_a, dato_b, ope_sel} !== {a, b, exp_op})
      $display("FAIL %s operands_held: got %h/%h/%h want %h/%h/%h", name, dato_a, dato_b, ope_sel, a, b, exp_op);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({dato_a, dato_b, ope_sel, tx_data, tx_start, busy} !== 32'h0)
      $display("FAIL reset_state: got a=%h b=%h op=%h tx=%h start=%b busy=%b want all 0",
               dato_a, dato_b, ope_sel, tx_data, tx_start, busy);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0 || tx_start !== 1'b0)
      $display("FAIL reset_release_idle: got busy=%b start=%b want 0/0", busy, tx_start);
    else pass_cnt++;
  endtask

  task automatic test_add();
    run_txn("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_add_carry();
    run_txn("add_carry", 8'hFF, 8'h01, 8'h20, 6'h20, 8'h00, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_sub_borrow();
    run_txn("sub_borrow", 8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if ({dato_a, dato_b, ope_sel, tx_data, tx_start, busy} !== 32'h0)
      $display("FAIL reset_mid_async: got a=%h b=%h op=%h tx=%h start=%b busy=%b want all 0",
               dato_a, dato_b, ope_sel, tx_data, tx_start, busy);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_byte(8'h20);
    total_cnt++;
    if (dato_a !== 8'h20 || dato_b !== 8'h00 || ope_sel !== 6'h00 || busy !== 1'b1)
      $display("FAIL reset_mid_lone_byte: got a=%h b=%h op=%h busy=%b want a=20 b=00 op=00 busy=1",
               dato_a, dato_b, ope_sel, busy);
    else pass_cnt++;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_start) pulses++;
    end
    total_cnt++;
    if (pulses != 0) $display("FAIL reset_mid_no_start: got %0d start pulses want 0", pulses);
    else pass_cnt++;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_opcode_mask();
    run_txn("op_mask_and", 8'h0F, 8'h0F, 8'hE4, 6'h24, 8'h0F, 8'h00, 1'b0, 1'b0);
    run_txn("op_invalid", 8'h0F, 8'h0F, 8'h3F, 6'h3F, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_dropped_bytes();
    run_txn("dropped_rx", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 8'h00, 1'b1, 1'b0);
  endtask

  // The A byte offered with the final i_tx_done is dropped; the next one, driven in
  // the very next cycle, must be accepted.
  task automatic test_back_to_back();
    run_txn("b2b_first", 8'h30, 8'h12, 8'h25, 6'h25, 8'h32, 8'h00, 1'b0, 1'b1);
    run_txn("b2b_second", 8'h40, 8'h41, 8'h22, 6'h22, 8'hFF, 8'h01, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_carry();
    test_sub_borrow();
    test_reset_mid_op();
    test_opcode_mask();
    test_dropped_bytes();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
